// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the default
// bit-period constant for 100 MHz / 115.2 kbps.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  localparam int WAITCNT_115200 = 868;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the
// value both flops take in reset (the idle level of the input).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-bit validation, centre sampling, a one-entry
// holding register and sticky framing-error / overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WAITCNT = WAITCNT_115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       re,
  output logic [7:0] dout,
  output logic       valid,
  output logic       ferr,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = WAITCNT / 2;
  localparam int WW   = $clog2(WAITCNT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(WAITCNT);
  localparam logic [WW-1:0] W_HALF = WW'(HALF);

  // r_state is the FSM state; kept as a named register for checker binding.
  uart_state_e   r_state, w_state_next;
  logic [WW-1:0] r_waitcnt, w_waitcnt_next;
  logic [3:0]    r_bitcnt, w_bitcnt_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [7:0]    r_dout;
  logic          r_valid, r_ferr, r_overrun, r_busy;
  logic          w_rxd_s, w_deliver, w_frame_err;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (din),
    .o_q   (w_rxd_s)
  );

  always_comb begin
    w_state_next   = r_state;
    w_waitcnt_next = r_waitcnt;
    w_bitcnt_next  = r_bitcnt;
    w_shift_next   = r_shift;
    w_deliver      = 1'b0;
    w_frame_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxd_s) begin
          w_state_next   = START;
          w_waitcnt_next = '0;
        end
      end
      START: begin
        if (r_waitcnt == W_HALF) begin
          w_waitcnt_next = '0;
          w_bitcnt_next  = 4'd0;
          // A start bit that is high again at its centre was only a glitch.
          w_state_next   = w_rxd_s ? IDLE : DATA;
        end else begin
          w_waitcnt_next = r_waitcnt + 1'b1;
        end
      end
      DATA: begin
        if (r_waitcnt == W_LAST) begin
          w_waitcnt_next = '0;
          w_shift_next   = {w_rxd_s, r_shift[7:1]};
          w_bitcnt_next  = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) w_state_next = STOP;
        end else begin
          w_waitcnt_next = r_waitcnt + 1'b1;
        end
      end
      STOP: begin
        if (r_waitcnt == W_LAST) begin
          w_waitcnt_next = '0;
          if (w_rxd_s) begin
            w_deliver    = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = BREAK;
          end
        end else begin
          w_waitcnt_next = r_waitcnt + 1'b1;
        end
      end
      BREAK: begin
        if (w_rxd_s) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_waitcnt <= '0;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'd0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_waitcnt <= w_waitcnt_next;
      r_bitcnt  <= w_bitcnt_next;
      r_shift   <= w_shift_next;
      r_busy    <= (w_state_next != IDLE);
    end
  end

  // Later assignments take priority: a delivery in the same cycle as re wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout    <= 8'd0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (re) begin
        r_valid   <= 1'b0;
        r_ferr    <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_frame_err) r_ferr <= 1'b1;
      if (w_deliver) begin
        r_dout  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !re) r_overrun <= 1'b1;
      end
    end
  end

  assign dout    = r_dout;
  assign valid   = r_valid;
  assign ferr    = r_ferr;
  assign overrun = r_overrun;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at WAITCNT=15: a serial transmitter model drives
// din, expected bytes go into a queue and a monitor checks each delivery.
module tb_uart_rx;

  localparam int WAITCNT = 15;
  localparam int BIT     = WAITCNT + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b1;
  logic       re = 1'b0;
  logic [7:0] dout;
  logic       valid, ferr, overrun, busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_dout = 8'd0;
  int         lat;

  uart_rx #(.WAITCNT(WAITCNT)) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .re      (re),
    .dout    (dout),
    .valid   (valid),
    .ferr    (ferr),
    .overrun (overrun),
    .busy    (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks: all called aligned to a falling clock edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task tx_frame(input logic [7:0] b, input logic stop_bit);
    din = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (BIT) @(negedge clk);
    end
    din = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  task pulse_re;
    @(negedge clk);
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  // scoreboard monitor: a new byte shows up as valid rising or dout changing while valid
  always @(negedge clk) begin
    if (valid && (!prev_valid || dout != prev_dout)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%0h required=none", dout);
      end else begin
        check("rx_byte", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = valid;
    prev_dout  = dout;
  end

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", ferr, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    idle(500);
    check("idle_dout", dout, 0);
    check("idle_valid", valid, 0);
    check("idle_busy", busy, 0);

    // 0x55 with exact latency: valid appears after posedge 154 counted from the first edge after the fall
    exp_q.push_back(8'h55);
    lat = -1;
    fork
      tx_frame(8'h55, 1'b1);
      begin
        wait (din == 1'b0);
        for (int i = 0; i < 300 && lat < 0; i++) begin
          @(posedge clk);
          #1;
          if (valid) lat = i;
        end
      end
    join
    check("valid_latency", lat, 154);
    pulse_re;
    check("re_clears_valid", valid, 0);

    // start glitch
    din = 1'b0;
    idle(4);
    din = 1'b1;
    check("glitch_busy_high", busy, 1);
    idle(20);
    check("glitch_busy_low", busy, 0);
    check("glitch_valid", valid, 0);
    check("glitch_ferr", ferr, 0);

    // framing error followed by a held-low line
    tx_frame(8'hA5, 1'b0);
    idle(40);
    check("brk_ferr", ferr, 1);
    check("brk_valid", valid, 0);
    check("brk_busy", busy, 1);
    din = 1'b1;
    idle(5);
    check("brk_release_busy", busy, 0);
    check("brk_ferr_sticky", ferr, 1);
    pulse_re;
    check("re_clears_ferr", ferr, 0);

    // overrun: two back-to-back frames without reading
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    tx_frame(8'h12, 1'b1);
    tx_frame(8'h34, 1'b1);
    check("ovr_dout", dout, 8'h34);
    check("ovr_valid", valid, 1);
    check("ovr_flag", overrun, 1);
    check("ovr_ferr", ferr, 0);

    // read acknowledge coincident with the next delivery
    idle(10);
    exp_q.push_back(8'h56);
    fork
      tx_frame(8'h56, 1'b1);
      begin
        wait (din == 1'b0);
        repeat (154) @(negedge clk);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
      end
    join
    check("coinc_dout", dout, 8'h56);
    check("coinc_valid", valid, 1);
    check("coinc_overrun", overrun, 0);

    // reset in the middle of a frame, while a byte is still held
    fork
      tx_frame(8'hFF, 1'b1);
      begin
        wait (din == 1'b0);
        repeat (BIT * 5 + 8) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    check("midrst_dout", dout, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ferr", ferr, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", busy, 0);

    exp_q.push_back(8'hC3);
    tx_frame(8'hC3, 1'b1);
    idle(5);
    check("post_dout", dout, 8'hC3);
    check("post_valid", valid, 1);
    check("post_ferr", ferr, 0);
    check("post_overrun", overrun, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
